// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the hazard controller.
//   - opcode constants and instruction class enum
//   - shadow-pipeline entry struct (valid, class, dst, latched rs/rt)
//   - forwarding-select encoding
//   - small decode helpers used by the top and its shadow stages
package hazard_pkg;

  localparam int HZ_RA_W = 5;  // register-address width carried in entries
  localparam int NUM_STG = 3;  // EX, MEM, WB
  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;

  localparam logic [5:0] OP_ALU   = 6'b000000;
  localparam logic [5:0] OP_CMP   = 6'b111110;
  localparam logic [5:0] OP_LOAD  = 6'b100011;
  localparam logic [5:0] OP_STORE = 6'b101011;

  typedef logic [HZ_RA_W-1:0] ra_t;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_CMP,
    CLS_LOAD,
    CLS_STORE,
    CLS_OTHER
  } cls_e;

  // rs/rt hold zero when the instruction does not read that field, and dst
  // holds zero when there is no destination; a zero register never matches.
  typedef struct packed {
    logic valid;
    cls_e cls;
    ra_t  dst;
    ra_t  rs;
    ra_t  rt;
  } entry_t;

  typedef enum logic [1:0] {
    FWD_RF     = 2'b00,
    FWD_EXMEM  = 2'b01,
    FWD_WB_ALU = 2'b10,
    FWD_WB_LD  = 2'b11
  } fwd_e;

  function automatic cls_e op_class(input logic [5:0] op);
    cls_e c;
    case (op)
      OP_ALU:   c = CLS_ALU;
      OP_CMP:   c = CLS_CMP;
      OP_LOAD:  c = CLS_LOAD;
      OP_STORE: c = CLS_STORE;
      default:  c = CLS_OTHER;
    endcase
    return c;
  endfunction

  function automatic logic alu_like(input cls_e c);
    return (c == CLS_ALU) || (c == CLS_CMP);
  endfunction

  function automatic logic reads_rt(input cls_e c);
    return (c == CLS_ALU) || (c == CLS_CMP) || (c == CLS_STORE);
  endfunction

  // EX/MEM wins over MEM/WB; register 0 is never forwarded.
  function automatic fwd_e fwd_pick(input ra_t r, input entry_t mem, input entry_t wb);
    fwd_e s;
    s = FWD_RF;
    if (r != '0) begin
      if (mem.valid && alu_like(mem.cls) && (mem.dst == r))
        s = FWD_EXMEM;
      else if (wb.valid && (wb.dst == r)) begin
        if (alu_like(wb.cls))        s = FWD_WB_ALU;
        else if (wb.cls == CLS_LOAD) s = FWD_WB_LD;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/hz_shadow_stage.sv
// hz_shadow_stage: one entry of the shadow pipeline.
//   clk, rst_n : clock, async active-low reset (clears the entry)
//   hold_i     : keep the current entry
//   load_i     : capture d_i; when low a bubble (all-zero entry) is captured
//   d_i / q_o  : incoming / registered entry
module hz_shadow_stage
  import hazard_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   hold_i,
  input  logic   load_i,
  input  entry_t d_i,
  output entry_t q_o
);

  entry_t ent_q, ent_d;

  always_comb begin
    ent_d = ent_q;
    if (!hold_i) ent_d = load_i ? d_i : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ent_q <= '0;
    else        ent_q <= ent_d;
  end

  assign q_o = ent_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall and operand-forwarding control for a 5-stage
// pipeline. A shadow copy of EX/MEM/WB tracks class and destination of the
// in-flight instructions; stall and forwarding selects are combinational
// from id_ir and that shadow state.
//   clk, rst_n           : clock, async active-low reset
//   id_valid, id_ir      : ID-stage instruction
//   flush                : squash the ID instruction (bubble into EX)
//   hold                 : freeze the whole pipeline (no stall asserted)
//   stall                : freeze PC and IF/ID, bubble into EX
//   fwd_a_sel, fwd_b_sel : EX operand source (see fwd_e)
//   stall_cnt            : saturating count of stall cycles, present only
//                          when HAZARD_PERF_EN is defined
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int RA_W = 5,
  parameter int IR_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [IR_W-1:0] id_ir,
  input  logic            flush,
  input  logic            hold,
  output logic            stall,
  output logic [1:0]      fwd_a_sel,
  output logic [1:0]      fwd_b_sel
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0]     stall_cnt
`endif
);

  // ID decode
  logic [5:0]      id_op;
  logic [RA_W-1:0] id_rs, id_rt, id_rd;
  entry_t          id_ent;

  assign id_op = id_ir[IR_W-1 -: 6];
  assign id_rs = id_ir[21 +: RA_W];
  assign id_rt = id_ir[16 +: RA_W];
  assign id_rd = id_ir[11 +: RA_W];

  always_comb begin
    id_ent       = '0;
    id_ent.valid = 1'b1;  // qualified by the EX stage load enable
    id_ent.cls   = op_class(id_op);
    case (id_ent.cls)
      CLS_ALU, CLS_CMP: id_ent.dst = id_rd;
      CLS_LOAD:         id_ent.dst = id_rt;
      default:          id_ent.dst = '0;
    endcase
    if (id_ent.cls != CLS_OTHER) id_ent.rs = id_rs;
    if (reads_rt(id_ent.cls))    id_ent.rt = id_rt;
  end

  // Shadow pipeline
  entry_t [NUM_STG-1:0] stg_d, stg_q;
  logic   [NUM_STG-1:0] stg_ld;
  logic                 ld_use;
  entry_t               ex_q;

  assign ex_q = stg_q[STG_EX];

  // Unread fields hold zero and dst is nonzero, so plain equality suffices.
  assign ld_use = id_valid && ex_q.valid && (ex_q.cls == CLS_LOAD) &&
                  (ex_q.dst != '0) &&
                  ((id_ent.rs == ex_q.dst) || (id_ent.rt == ex_q.dst));

  assign stall = ld_use && !flush && !hold;

  // Only EX can take a bubble from the ID side; later stages always shift,
  // the bubble travelling as valid=0.
  assign stg_d[STG_EX]         = id_ent;
  assign stg_d[NUM_STG-1:1]    = stg_q[NUM_STG-2:0];
  assign stg_ld[STG_EX]        = id_valid && !stall && !flush;
  assign stg_ld[NUM_STG-1:1]   = '1;

  for (genvar g = 0; g < NUM_STG; g++) begin : g_stg
    hz_shadow_stage u_stg (
      .clk    (clk),
      .rst_n  (rst_n),
      .hold_i (hold),
      .load_i (stg_ld[g]),
      .d_i    (stg_d[g]),
      .q_o    (stg_q[g])
    );
  end

  // Forwarding for the instruction currently in EX
  ra_t op_a, op_b;
  assign op_a = ex_q.valid ? ex_q.rs : '0;
  assign op_b = ex_q.valid ? ex_q.rt : '0;

  assign fwd_a_sel = fwd_pick(op_a, stg_q[STG_MEM], stg_q[STG_WB]);
  assign fwd_b_sel = fwd_pick(op_b, stg_q[STG_MEM], stg_q[STG_WB]);

  logic unused_bits;
  assign unused_bits = ^{id_ir[10:0], stg_q[STG_WB].rs, stg_q[STG_WB].rt};

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed bench for hazard_ctrl. A raw-instruction model of
// EX/MEM/WB predicts stall / forwarding every cycle; literal expectations on
// key cycles pin the model. Honours HAZARD_PERF_EN for stall_cnt.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [31:0] id_ir = '0;
  logic        flush = 1'b0;
  logic        hold = 1'b0;
  logic        stall;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt;
`endif

  hazard_ctrl #(.RA_W(5), .IR_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .id_valid  (id_valid),
    .id_ir     (id_ir),
    .flush     (flush),
    .hold      (hold),
    .stall     (stall),
    .fwd_a_sel (fwd_a_sel),
    .fwd_b_sel (fwd_b_sel)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [31:0] NOP = 32'h2000_0000;  // addi: class OTHER

  function automatic logic [31:0] alu(input int rd, input int rs, input int rt);
    return {6'b000000, rs[4:0], rt[4:0], rd[4:0], 11'h020};
  endfunction
  function automatic logic [31:0] cmp(input int rd, input int rs, input int rt);
    return {6'b111110, rs[4:0], rt[4:0], rd[4:0], 11'h000};
  endfunction
  function automatic logic [31:0] lw(input int rt, input int rs);
    return {6'b100011, rs[4:0], rt[4:0], 16'h0004};
  endfunction

  // ---------------- model: raw instruction words per stage ----------------
  bit          m_v [3];   // 0=EX 1=MEM 2=WB
  logic [31:0] m_ir [3];
  int          m_cnt;

  // 0 ALU, 1 CMP, 2 LOAD, 3 STORE, 4 OTHER
  function automatic int cls_of(input logic [31:0] ir);
    case (ir[31:26])
      6'b000000: return 0;
      6'b111110: return 1;
      6'b100011: return 2;
      6'b101011: return 3;
      default:   return 4;
    endcase
  endfunction
  function automatic int dst_of(input logic [31:0] ir);
    int c = cls_of(ir);
    if (c <= 1) return int'(ir[15:11]);
    if (c == 2) return int'(ir[20:16]);
    return 0;
  endfunction
  // k=0: rs operand, k=1: rt operand; 0 when that field is not read
  function automatic int src_of(input logic [31:0] ir, input int k);
    int c = cls_of(ir);
    if (c == 4) return 0;
    if (k == 0) return int'(ir[25:21]);
    if (c == 2) return 0;
    return int'(ir[20:16]);
  endfunction
  function automatic int exp_stall();
    int d;
    if (hold || flush || !id_valid || !m_v[0] || cls_of(m_ir[0]) != 2) return 0;
    d = dst_of(m_ir[0]);
    if (d == 0) return 0;
    return (src_of(id_ir, 0) == d || src_of(id_ir, 1) == d) ? 1 : 0;
  endfunction
  function automatic int exp_fwd(input int k);
    int r = m_v[0] ? src_of(m_ir[0], k) : 0;
    if (r == 0) return 0;
    if (m_v[1] && cls_of(m_ir[1]) <= 1 && dst_of(m_ir[1]) == r) return 1;
    if (m_v[2] && dst_of(m_ir[2]) == r) return (cls_of(m_ir[2]) == 2) ? 3 : 2;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) m_v[i] <= 1'b0;
      m_cnt <= 0;
    end else if (!hold) begin
      m_v[2]  <= m_v[1];  m_ir[2] <= m_ir[1];
      m_v[1]  <= m_v[0];  m_ir[1] <= m_ir[0];
      m_v[0]  <= id_valid && !flush && (exp_stall() == 0);
      m_ir[0] <= id_ir;
      if (exp_stall() != 0 && m_cnt != 65535) m_cnt <= m_cnt + 1;
    end
  end

  // ---------------- compare process ----------------
  int    n_chk = 0;
  int    n_bad = 0;
  string lit_nm = "";
  int    lit_st = -1, lit_a = -1, lit_b = -1, lit_c = -1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("model.stall", int'(stall), exp_stall());
      chk("model.fwd_a", int'(fwd_a_sel), exp_fwd(0));
      chk("model.fwd_b", int'(fwd_b_sel), exp_fwd(1));
`ifdef HAZARD_PERF_EN
      chk("model.stall_cnt", int'(stall_cnt), m_cnt);
      if (lit_c >= 0) chk({lit_nm, ".cnt"}, int'(stall_cnt), lit_c);
`endif
      if (lit_st >= 0) chk({lit_nm, ".stall"}, int'(stall), lit_st);
      if (lit_a >= 0)  chk({lit_nm, ".fwd_a"}, int'(fwd_a_sel), lit_a);
      if (lit_b >= 0)  chk({lit_nm, ".fwd_b"}, int'(fwd_b_sel), lit_b);
    end
  end

  // ---------------- stimulus ----------------
  task automatic put(input logic v, input logic [31:0] ir,
                     input logic fl = 1'b0, input logic hd = 1'b0);
    id_valid = v; id_ir = ir; flush = fl; hold = hd;
    lit_st = -1; lit_a = -1; lit_b = -1; lit_c = -1;
  endtask
  task automatic want(input string nm, input int st, input int a, input int b);
    lit_nm = nm; lit_st = st; lit_a = a; lit_b = b;
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    // reset
    put(1'b0, '0); want("rst", 0, 0, 0); tick(); tick();
    rst_n = 1'b1;
    put(1'b1, NOP); want("post_rst", 0, 0, 0); tick();

    // load-use: one stall, then MEM/WB load data into operand A
    put(1'b1, lw(2, 1)); tick();
    put(1'b1, alu(3, 2, 4)); want("lu_stall", 1, 0, 0); tick();
    put(1'b1, alu(3, 2, 4)); want("lu_bubble", 0, 0, 0); tick();
    put(1'b1, NOP); want("lu_fwd", 0, 3, 0); tick();
    put(1'b1, NOP); tick(); put(1'b1, NOP); tick();

    // back-to-back ALU dependency
    put(1'b1, alu(5, 1, 2)); tick();
    put(1'b1, alu(6, 5, 5)); want("b2b_id", 0, 0, 0); tick();
    put(1'b1, NOP); want("b2b_fwd", 0, 1, 1); tick();

    // EX/MEM beats MEM/WB; then MEM/WB ALU alone
    put(1'b1, cmp(5, 1, 2)); tick();
    put(1'b1, alu(5, 3, 4)); tick();
    put(1'b1, alu(7, 5, 0)); tick();
    put(1'b1, NOP); want("prio", 0, 1, 0); tick();
    put(1'b1, alu(8, 1, 1)); tick();
    put(1'b1, NOP); tick();
    put(1'b1, alu(9, 8, 0)); tick();
    put(1'b1, NOP); want("wb_alu", 0, 2, 0); tick();

    // register 0 never forwarded, never stalls
    put(1'b1, alu(0, 1, 2)); tick();
    put(1'b1, alu(3, 0, 0)); tick();
    put(1'b1, NOP); want("r0_fwd", 0, 0, 0); tick();
    put(1'b1, lw(0, 1)); tick();
    put(1'b1, alu(4, 0, 0)); want("lw_r0", 0, 0, 0); tick();
    put(1'b1, NOP); tick(); put(1'b1, NOP); tick();

    // flush beats stall; the squashed add must not appear downstream
    put(1'b1, lw(2, 1)); tick();
    put(1'b1, alu(3, 2, 4), 1'b1); want("flush", 0, 0, 0); tick();
    put(1'b1, alu(7, 3, 3)); want("post_flush", 0, 0, 0); tick();
    put(1'b1, NOP); want("flush_bubble", 0, 0, 0); tick();

    // hold freezes forwarding state
    put(1'b1, alu(5, 1, 2)); tick();
    put(1'b1, alu(6, 5, 5)); tick();
    for (int i = 0; i < 3; i++) begin
      put(1'b1, NOP, 1'b0, 1'b1); want("hold_sel", 0, 1, 1); tick();
    end
    put(1'b1, NOP); want("hold_rel", 0, 1, 1); tick();

    // hold masks a load-use stall, which reappears once released
    put(1'b1, lw(2, 1)); tick();
    for (int i = 0; i < 2; i++) begin
      put(1'b1, alu(3, 2, 4), 1'b0, 1'b1); want("hold_nostall", 0, 0, 0); tick();
    end
    put(1'b1, alu(3, 2, 4)); want("hold_then_stall", 1, 0, 0); tick();
    put(1'b1, alu(3, 2, 4)); tick();
    put(1'b1, NOP); tick(); put(1'b1, NOP); tick();

    // fresh reset, five load-use stalls
    rst_n = 1'b0;
    put(1'b0, '0); want("rst2", 0, 0, 0); lit_c = 0; tick();
    rst_n = 1'b1;
    put(1'b1, NOP); tick();
    for (int i = 0; i < 5; i++) begin
      put(1'b1, lw(2, 1)); tick();
      put(1'b1, alu(3, 2, 4)); want("lu_n", 1, 0, 0); tick();
      put(1'b1, alu(3, 2, 4)); tick();
    end
    put(1'b1, NOP); lit_nm = "five_stalls"; lit_c = 5; tick();

    // reset in the middle of live forwarding
    put(1'b1, alu(5, 1, 2)); tick();
    put(1'b1, alu(6, 5, 5)); tick();
    put(1'b1, NOP, 1'b0, 1'b1); want("pre_rst", 0, 1, 1); tick();
    put(1'b1, NOP, 1'b0, 1'b1); rst_n = 1'b0;
    want("mid_rst", 0, 0, 0); lit_c = 0; tick();
    rst_n = 1'b1;
    put(1'b1, alu(7, 5, 5)); want("first_post", 0, 0, 0); lit_c = 0; tick();
    put(1'b1, NOP); want("post_rst_fwd", 0, 0, 0); tick();
    put(1'b0, NOP); tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
